// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y raster counters, and
// registered sync/blank decodes aligned to the current counter values.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       Hsynq,
    output logic       Vsynq,
    output logic       video_on,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int unsigned PIX_W   = 10;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PIX_W-1:0] H_LAST   = PIX_W'(H_TOTAL - 1);
    localparam logic [PIX_W-1:0] V_LAST   = PIX_W'(V_TOTAL - 1);
    localparam logic [PIX_W-1:0] H_VIS    = PIX_W'(H_VISIBLE);
    localparam logic [PIX_W-1:0] V_VIS    = PIX_W'(V_VISIBLE);
    localparam logic [PIX_W-1:0] HS_FIRST = PIX_W'(H_VISIBLE + H_FP);
    localparam logic [PIX_W-1:0] HS_LAST  = PIX_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [PIX_W-1:0] VS_FIRST = PIX_W'(V_VISIBLE + V_FP);
    localparam logic [PIX_W-1:0] VS_LAST  = PIX_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [PIX_W-1:0] x_q, x_d;
    logic [PIX_W-1:0] y_q, y_d;
    logic             hsynq_q, hsynq_d;
    logic             vsynq_q, vsynq_d;
    logic             video_q, video_d;
    logic             started_q, started_d;
    logic             tick_c;
    logic             line_end_c;
    logic             frame_end_c;

    // Next-state counters; sync/blank decode the next-state values so the
    // registered outputs line up with the counters they describe.
    always_comb begin
        div_d     = div_q;
        x_d       = x_q;
        y_d       = y_q;
        started_d = started_q;

        tick_c      = rst_n && en && (div_q == DIV_LAST);
        line_end_c  = (x_q == H_LAST);
        frame_end_c = line_end_c && (y_q == V_LAST);

        if (en) begin
            div_d = tick_c ? '0 : div_q + DIV_W'(1);
        end

        if (tick_c) begin
            started_d = 1'b1;
            if (line_end_c) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + PIX_W'(1);
            end else begin
                x_d = x_q + PIX_W'(1);
            end
        end

        hsynq_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsynq_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        // The reset pixel stays blanked until the first pixel advance.
        video_d = en && started_d && (x_d < H_VIS) && (y_d < V_VIS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            hsynq_q   <= 1'b1;
            vsynq_q   <= 1'b1;
            video_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            x_q       <= x_d;
            y_q       <= y_d;
            hsynq_q   <= hsynq_d;
            vsynq_q   <= vsynq_d;
            video_q   <= video_d;
            started_q <= started_d;
        end
    end

    assign Hsynq       = hsynq_q;
    assign Vsynq       = vsynq_q;
    assign video_on    = video_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_tick    = tick_c;
    assign frame_start = tick_c && frame_end_c;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x8 raster (CLK_DIV=2),
// plus a CLK_DIV=1 instance sharing the same controls.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       hs, vs, von, tick, fs;
    logic [9:0] px, py;
    logic       hs1, vs1, von1, tick1, fs1;
    logic [9:0] px1, py1;

    int checks;
    int failures;
    int n_edge;

    // Raster: H 8+2+3+3=16 (sync x=10..12), V 4+1+2+1=8 (sync y=5..6).
    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Hsynq(hs), .Vsynq(vs), .video_on(von),
        .pix_x(px), .pix_y(py), .pix_tick(tick), .frame_start(fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .Hsynq(hs1), .Vsynq(vs1), .video_on(von1),
        .pix_x(px1), .pix_y(py1), .pix_tick(tick1), .frame_start(fs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the negedge following the given posedge count since release.
    task automatic goto_edge(input int target);
        while (n_edge < target) begin
            @(negedge clk);
            n_edge++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        en    = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (px !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", px); end
        checks++; if (py !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", py); end
        checks++; if (hs !== 1'b1) begin failures++; $display("FAIL reset_hs got=%b exp=1", hs); end
        checks++; if (vs !== 1'b1) begin failures++; $display("FAIL reset_vs got=%b exp=1", vs); end
        checks++; if (von !== 1'b0) begin failures++; $display("FAIL reset_video got=%b exp=0", von); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (fs !== 1'b0) begin failures++; $display("FAIL reset_fs got=%b exp=0", fs); end
        checks++; if (tick1 !== 1'b0) begin failures++; $display("FAIL reset_tick_div1 got=%b exp=0", tick1); end
        rst_n  = 1'b1;
        n_edge = 0;
    endtask

    task automatic test_first_tick;
        goto_edge(1);
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL first_tick got=%b exp=1", tick); end
        checks++; if (px !== 10'd0) begin failures++; $display("FAIL first_tick_x got=%0d exp=0", px); end
        checks++; if (von !== 1'b0) begin failures++; $display("FAIL first_pixel_blank got=%b exp=0", von); end
        goto_edge(2);
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL tick_low got=%b exp=0", tick); end
        checks++; if (px !== 10'd1) begin failures++; $display("FAIL x_after_tick got=%0d exp=1", px); end
        checks++; if (von !== 1'b1) begin failures++; $display("FAIL video_x1 got=%b exp=1", von); end
        checks++; if (px1 !== 10'd2) begin failures++; $display("FAIL div1_x got=%0d exp=2", px1); end
        checks++; if (tick1 !== 1'b1) begin failures++; $display("FAIL div1_tick got=%b exp=1", tick1); end
    endtask

    task automatic test_hsync;
        goto_edge(15);
        checks++; if (von !== 1'b1) begin failures++; $display("FAIL video_x7 got=%b exp=1", von); end
        goto_edge(16);
        checks++; if (von !== 1'b0) begin failures++; $display("FAIL video_x8 got=%b exp=0", von); end
        goto_edge(19);
        checks++; if (hs !== 1'b1) begin failures++; $display("FAIL hs_x9 got=%b exp=1", hs); end
        goto_edge(20);
        checks++; if (hs !== 1'b0 || px !== 10'd10) begin failures++; $display("FAIL hs_fall got=%b/x%0d exp=0/x10", hs, px); end
        goto_edge(25);
        checks++; if (hs !== 1'b0) begin failures++; $display("FAIL hs_x12 got=%b exp=0", hs); end
        goto_edge(26);
        checks++; if (hs !== 1'b1) begin failures++; $display("FAIL hs_rise got=%b exp=1", hs); end
        goto_edge(51);
        checks++; if (hs !== 1'b1) begin failures++; $display("FAIL hs_line1_x9 got=%b exp=1", hs); end
        goto_edge(52);
        checks++; if (hs !== 1'b0 || py !== 10'd1) begin failures++; $display("FAIL hs_fall2 got=%b/y%0d exp=0/y1", hs, py); end
    endtask

    task automatic test_vsync_frame;
        goto_edge(159);
        checks++; if (vs !== 1'b1 || px !== 10'd15 || py !== 10'd4) begin
            failures++; $display("FAIL pre_vsync got=%b (%0d,%0d) exp=1 (15,4)", vs, px, py); end
        goto_edge(160);
        checks++; if (vs !== 1'b0 || px !== 10'd0 || py !== 10'd5) begin
            failures++; $display("FAIL vs_fall got=%b (%0d,%0d) exp=0 (0,5)", vs, px, py); end
        checks++; if (von !== 1'b0) begin failures++; $display("FAIL video_blank_line got=%b exp=0", von); end
        goto_edge(223);
        checks++; if (vs !== 1'b0) begin failures++; $display("FAIL vs_y6 got=%b exp=0", vs); end
        goto_edge(224);
        checks++; if (vs !== 1'b1) begin failures++; $display("FAIL vs_rise got=%b exp=1", vs); end
        goto_edge(254);
        checks++; if (fs !== 1'b0) begin failures++; $display("FAIL fs_early got=%b exp=0", fs); end
        goto_edge(255);
        checks++; if (fs !== 1'b1 || tick !== 1'b1) begin failures++; $display("FAIL frame_start got=%b/%b exp=1/1", fs, tick); end
        goto_edge(256);
        checks++; if (fs !== 1'b0 || px !== 10'd0 || py !== 10'd0) begin
            failures++; $display("FAIL frame_wrap got=%b (%0d,%0d) exp=0 (0,0)", fs, px, py); end
        checks++; if (von !== 1'b1) begin failures++; $display("FAIL video_frame2_origin got=%b exp=1", von); end
    endtask

    task automatic test_enable_hold;
        goto_edge(297);
        checks++; if (px !== 10'd4 || py !== 10'd1 || von !== 1'b1) begin
            failures++; $display("FAIL pre_pause got=(%0d,%0d) v%b exp=(4,1) v1", px, py, von); end
        checks++; if (px1 !== 10'd9 || py1 !== 10'd2) begin
            failures++; $display("FAIL div1_pre_pause got=(%0d,%0d) exp=(9,2)", px1, py1); end
        en = 1'b0;
        #1;
        checks++; if (tick !== 1'b0 || tick1 !== 1'b0) begin failures++; $display("FAIL pause_tick got=%b/%b exp=0/0", tick, tick1); end
        repeat (10) @(negedge clk);
        checks++; if (px !== 10'd4 || py !== 10'd1) begin failures++; $display("FAIL pause_hold got=(%0d,%0d) exp=(4,1)", px, py); end
        checks++; if (von !== 1'b0 || fs !== 1'b0 || hs !== 1'b1) begin
            failures++; $display("FAIL pause_outputs got=v%b f%b h%b exp=v0 f0 h1", von, fs, hs); end
        checks++; if (px1 !== 10'd9) begin failures++; $display("FAIL div1_pause_hold got=%0d exp=9", px1); end
        en = 1'b1;
        #1;
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL resume_tick got=%b exp=1", tick); end
        @(negedge clk);
        checks++; if (px !== 10'd5 || von !== 1'b1) begin failures++; $display("FAIL resume_x got=%0d v%b exp=5 v1", px, von); end
        repeat (9) @(negedge clk);
        checks++; if (hs !== 1'b1 || px !== 10'd9) begin failures++; $display("FAIL resume_hs_pre got=%b x%0d exp=1 x9", hs, px); end
        @(negedge clk);
        checks++; if (hs !== 1'b0 || px !== 10'd10) begin failures++; $display("FAIL resume_hs_fall got=%b x%0d exp=0 x10", hs, px); end
        en = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hs !== 1'b0 || px !== 10'd10) begin failures++; $display("FAIL pause_hs_hold got=%b x%0d exp=0 x10", hs, px); end
        en = 1'b1;
    endtask

    task automatic test_reset_midsync;
        rst_n = 1'b0;
        #1;
        checks++; if (hs !== 1'b1 || px !== 10'd0 || py !== 10'd0) begin
            failures++; $display("FAIL midsync_reset got=h%b (%0d,%0d) exp=h1 (0,0)", hs, px, py); end
        checks++; if (von !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL midsync_reset_vt got=%b/%b exp=0/0", von, tick); end
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        n_edge = 0;
        goto_edge(1);
        checks++; if (tick !== 1'b1 || px !== 10'd0 || von !== 1'b0) begin
            failures++; $display("FAIL restart_first got=t%b x%0d v%b exp=t1 x0 v0", tick, px, von); end
        goto_edge(2);
        checks++; if (px !== 10'd1 || von !== 1'b1) begin failures++; $display("FAIL restart_second got=x%0d v%b exp=x1 v1", px, von); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_edge   = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        test_reset;
        test_first_tick;
        test_hsync;
        test_vsync_frame;
        test_enable_hold;
        test_reset_midsync;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
